// File: rtl/ccs_pkg.sv
// ---------------------------------------------------------------------------
// ccs_pkg
// Shared definitions for the CCI (I2C with 16-bit register index) blocks.
//   CCS_INDEX_WIDTH : width of the register index carried on the CCI bus
//   ccs_state_e     : byte-level protocol states of a CCI target
//   ccs_ack_next    : where a target goes once an ACK bit has been released
// ---------------------------------------------------------------------------
package ccs_pkg;

    localparam int CCS_INDEX_WIDTH = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_IDX_HI,
        ST_IDX_HI_ACK,
        ST_IDX_LO,
        ST_IDX_LO_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } ccs_state_e;

    // After the target has held SDA low for one ACK clock it moves on to the
    // next byte phase. A read address hands over to the read data phase; every
    // other ACK leads into the next byte the initiator is about to write.
    function automatic ccs_state_e ccs_ack_next(input ccs_state_e cur, input logic rw);
        ccs_state_e nxt;
        case (cur)
            ST_ADDR_ACK:   nxt = rw ? ST_RD_DATA : ST_IDX_HI;
            ST_IDX_HI_ACK: nxt = ST_IDX_LO;
            default:       nxt = ST_WR_DATA;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
// Brings the asynchronous SCL/SDA pins into the clk_in domain and turns them
// into single-cycle bus events.
//   clk_in    : system clock (at least 20x the SCL rate)
//   reset     : synchronous, active-high
//   scl_in    : raw SCL pin level
//   sda_in    : raw SDA pin level
//   scl_rise  : one-cycle pulse, SCL went high (sample point)
//   scl_fall  : one-cycle pulse, SCL went low (SDA may change)
//   start_det : one-cycle pulse, SDA fell while SCL was high
//   stop_det  : one-cycle pulse, SDA rose while SCL was high
//   sda_bit   : synchronised SDA level, aligned with the pulses above
// A pin change shows up on the pulse outputs three clk_in cycles later
// (two synchroniser stages plus one registered edge stage).
// ---------------------------------------------------------------------------
module i2c_bus_monitor (
    input  logic clk_in,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_hist_q, sda_hist_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic sda_bit_q, sda_bit_d;

    // Synchroniser chain plus one history stage, and edge/condition decode.
    // START/STOP require SCL to be high in both the current and previous
    // sample so that an SDA change racing an SCL edge is not misread.
    always_comb begin
        scl_meta_d = scl_in;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = sda_in;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
        scl_rise_d = scl_sync_q & ~scl_hist_q;
        scl_fall_d = ~scl_sync_q & scl_hist_q;
        start_d    = scl_sync_q & scl_hist_q & ~sda_sync_q & sda_hist_q;
        stop_d     = scl_sync_q & scl_hist_q & sda_sync_q & ~sda_hist_q;
        sda_bit_d  = sda_sync_q;
    end

    // The idle bus is pulled high, so the synchronisers come out of reset
    // at 1 to avoid inventing an edge right after reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_hist_q <= sda_hist_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            sda_bit_q  <= sda_bit_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_bit   = sda_bit_q;

endmodule

// File: rtl/ccs_target.sv
// ---------------------------------------------------------------------------
// ccs_target
// CCI target: device address match, big-endian 16-bit register index, and
// one strobe per data byte on a simple register port.
//   ADDRESS   : 8-bit form device address, bits [7:1] are matched
//   clk_in    : system clock, at least 20x the SCL rate
//   reset     : synchronous, active-high
//   scl       : I2C clock, only ever read (no clock stretching)
//   sda       : I2C data, open-drain (driven low or released)
//   reg_addr  : current register index
//   reg_wdata : write data, valid while reg_we is high
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read data, captured one cycle after reg_re
//   busy      : high from an address-matched START until STOP or read NACK
// ---------------------------------------------------------------------------
module ccs_target
    import ccs_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h6c
) (
    input  logic                       clk_in,
    input  logic                       reset,
    inout  wire                        scl,
    inout  wire                        sda,
    output logic [CCS_INDEX_WIDTH-1:0] reg_addr,
    output logic [7:0]                 reg_wdata,
    output logic                       reg_we,
    output logic                       reg_re,
    input  logic [7:0]                 reg_rdata,
    output logic                       busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_bit;

    ccs_state_e                 state_q, state_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shreg_q, shreg_d;
    logic [7:0]                 idx_hi_q, idx_hi_d;
    logic [CCS_INDEX_WIDTH-1:0] index_q, index_d;
    logic                       rw_q, rw_d;
    logic                       ack_on_q, ack_on_d;
    logic                       sda_oe_q, sda_oe_d;
    logic                       busy_q, busy_d;
    logic                       we_q, we_d;
    logic                       re_q, re_d;
    logic [7:0]                 wdata_q, wdata_d;
    logic                       load_q, load_d;

    logic [7:0] rx_byte;
    logic       byte_last;

    i2c_bus_monitor u_mon (
        .clk_in    (clk_in),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    // SCL is never held low by this target, SDA is open-drain.
    assign scl = 1'bz;
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Protocol engine. Priority is STOP, then START, then the per-state
    // handling of SCL edges. Bits are taken on SCL rise, SDA is only moved
    // on SCL fall so this target never fakes a START/STOP of its own.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        idx_hi_d  = idx_hi_q;
        index_d   = index_q;
        rw_d      = rw_q;
        ack_on_d  = ack_on_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        wdata_d   = wdata_q;
        load_d    = re_q;
        rx_byte   = {shreg_q[6:0], sda_bit};
        byte_last = (bit_cnt_q == 3'd7);

        // The index steps on the cycle after a write strobe so the strobe
        // itself still presents the address the byte belongs to.
        if (we_q) begin
            index_d = index_q + CCS_INDEX_WIDTH'(1);
        end

        // Read data arrives one cycle after reg_re and is captured here,
        // well before the SCL fall that puts its MSB on the bus.
        if (load_q) begin
            shreg_d = reg_rdata;
        end

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            ack_on_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            ack_on_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_last) begin
                            if (rx_byte[7:1] == ADDRESS[7:1]) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                re_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                ST_IDX_HI: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_last) begin
                            idx_hi_d = rx_byte;
                            state_d  = ST_IDX_HI_ACK;
                        end
                    end
                end

                ST_IDX_LO: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_last) begin
                            index_d = {idx_hi_q, rx_byte};
                            state_d = ST_IDX_LO_ACK;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_last) begin
                            we_d    = 1'b1;
                            wdata_d = rx_byte;
                            state_d = ST_WR_ACK;
                        end
                    end
                end

                // First SCL fall after bit 8 pulls SDA low, the next one ends
                // the ACK. Entering a read, the MSB of the fetched byte goes
                // out on that same fall, so a 0 simply keeps SDA low.
                ST_ADDR_ACK, ST_IDX_HI_ACK, ST_IDX_LO_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_oe_d = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ccs_ack_next(state_q, rw_q);
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                sda_oe_d = ~shreg_q[7];
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                // The shift register is consumed MSB first: each rise moves
                // the next bit into [7], each fall puts [7] on the bus.
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_last) begin
                            state_d = ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~shreg_q[7];
                    end
                end

                // SDA is handed back to the initiator for its ACK bit. An ACK
                // fetches the next register; a NACK ends the transfer.
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_d = 3'd0;
                        if (!sda_bit) begin
                            index_d = index_q + CCS_INDEX_WIDTH'(1);
                            re_d    = 1'b1;
                            state_d = ST_RD_DATA;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State register. Reset drops the SDA driver on the very next edge and
    // clears the index; everything else waits for a fresh START.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            idx_hi_q  <= 8'h00;
            index_q   <= '0;
            rw_q      <= 1'b0;
            ack_on_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            wdata_q   <= 8'h00;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            idx_hi_q  <= idx_hi_d;
            index_q   <= index_d;
            rw_q      <= rw_d;
            ack_on_q  <= ack_on_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            re_q      <= re_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
        end
    end

    assign reg_addr  = index_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

endmodule

// File: doc/ccs_target.md
# ccs_target

CCI (I2C, 16-bit register index) target that answers an on-chip or bench-side CCI initiator such as the sensor controllers in this codebase. It decodes START/STOP, matches a 7-bit device address, latches a big-endian 16-bit register index, and turns each data byte into a single-cycle write or read strobe on a simple register port. The block serves as the sensor model in controller testbenches and as the target side of FPGA-to-FPGA CCI links.

## Interface
- `ADDRESS`, default 8'h6c: device address in 8-bit form; bit 0 ignored, bits [7:1] matched.
- `clk_in` input 1: system clock, must be at least 20x the SCL rate.
- `reset` input 1: synchronous, active-high.
- `scl` inout wire 1: I2C clock; never driven (no clock stretching), always 'z.
- `sda` inout wire 1: I2C data; open-drain, driven 1'b0 or 'z only.
- `reg_addr` output 16: current register index.
- `reg_wdata` output 8: write data, valid while `reg_we` is high.
- `reg_we` output 1: one-cycle write strobe.
- `reg_re` output 1: one-cycle read strobe.
- `reg_rdata` input 8: read data, sampled exactly 1 cycle after `reg_re`.
- `busy` output 1: high from an address-matched START until STOP or NACK-idle.

## Operation
- Front end: `scl`/`sda` 2-flop synchronised, plus 1 history flop for edge detection.
- START is SDA falling while SCL high. STOP is SDA rising while SCL high. Repeated START is a START while not idle.
- Bits are sampled on synced SCL rising. SDA is changed only on synced SCL falling.
- FSM states: IDLE, ADDR, ADDR_ACK, IDX_HI, IDX_HI_ACK, IDX_LO, IDX_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START from any state goes to ADDR with a bit counter of 0. STOP from any state goes to IDLE and releases SDA.
- ADDR: shift in 8 bits.
  - If [7:1] != ADDRESS[7:1], go to IDLE with no ACK and ignore the bus until the next START.
  - If it matches, drive ACK. R/W=0 goes to IDX_HI. R/W=1 pulses `reg_re` with `reg_addr` = index, loads `reg_rdata` into the shift register, then goes to RD_DATA.
- IDX_HI, then IDX_LO: each byte is ACKed. The index becomes {hi, lo} on the 8th bit of IDX_LO. Then go to WR_DATA.
- WR_DATA: on the 8th bit, pulse `reg_we` for 1 cycle with `reg_wdata` = byte and `reg_addr` = index. ACK the byte. Index increments after the strobe.
- RD_DATA: drive the MSB first. After 8 bits, release SDA and sample the initiator's ACK in RD_ACK.
  - ACK (0): index++, pulse `reg_re`, and load the next byte.
  - NACK (1): go to IDLE and wait for STOP or START.
- Index increment wraps 16'hffff -> 16'h0000.
- The index persists across STOP and repeated START. A write-index / repeated-START / read sequence therefore reads from the written index.
- Index resets to 0 on `reset` only.
- ACK: drive SDA low on the SCL falling edge after bit 8, and release it on the next SCL falling edge. In a read, if the next bit is 0, keep SDA low instead of releasing it.
- Reset in the middle of a transfer: SDA is released immediately, state goes to IDLE, and the rest of the transfer is ignored until a fresh START.

## Timing
- Reset values: `sda` 'z, `scl` 'z, `reg_we` 0, `reg_re` 0, `reg_wdata` 0, `reg_addr` 0, `busy` 0. Internal index 0, state IDLE.
- Pin-to-detect latency: 3 `clk_in` cycles (2 sync + 1 edge).
- SDA output changes 4 cycles after the physical SCL falling edge.
- `reg_re` to `reg_rdata` sample: 1 cycle. `reg_rdata` must be stable from cycle+1 until the load.
- `reg_we` and `reg_re` are never high together. Each is high for exactly 1 cycle per byte.
- `busy` rises in the cycle ADDR_ACK is entered with a match. It falls on the cycle STOP is detected, or on NACK to IDLE.

## Structure
- `ccs_pkg`: the FSM state enum and the `CCS_INDEX_WIDTH = 16` constant. Shared with future CCI blocks.
- Sub-module `i2c_bus_monitor`: synchronisers, SCL rise/fall pulses, START/STOP pulses, synced SDA bit. The top holds the FSM, shifter, index, and open-drain drivers.

## Test plan
- **Write burst:** write 0x6c, idx 0x3034, data 0x08,0x41 -> `reg_we` pulses twice with (0x3034,0x08) then (0x3035,0x41). Every byte is ACKed.
- **Combined read:** write 0x6c, idx 0x300a, Sr, 0x6d, read 2 bytes with ACK then NACK, `reg_rdata` = addr-keyed model -> returns 0x56, 0x47. `reg_re` is seen at 0x300a and 0x300b only.
- **Wrong address:** 0x6e -> no ACK (SDA stays 'z), no strobes, `busy` stays 0. A following valid transfer is accepted.
- **Index wrap:** idx 0xffff, write 2 bytes -> strobes at 0xffff, then 0x0000.
- **Reset mid-byte:** assert `reset` during bit 4 of a data byte -> SDA is 'z next cycle, no `reg_we`, index 0. The next full transfer works.
- **STOP mid-byte:** STOP after 3 data bits -> no `reg_we`, `busy` falls, state IDLE.
